// File: rtl/video_sync_norm.sv
// Normalises hsync/vsync of unknown polarity to active-low and blanks RGB while either sync is active.
// Optional composite sync output enabled by defining CSYNC_EN.
module video_sync_norm #(
  parameter int unsigned HCNT_W = 12,
  parameter int unsigned VCNT_W = 10
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic [5:0] r_out,
  output logic [5:0] g_out,
  output logic [5:0] b_out,
  output logic       csync_out,
  output logic       hpol,
  output logic       vpol
);
  localparam int unsigned RGB_W = 18;
  localparam logic [HCNT_W-1:0] HMAX = '1;
  localparam logic [VCNT_W-1:0] VMAX = '1;

  logic             r_hs_d, r_vs_d, r_hs_dd, r_vs_dd, r_stg_vld;
  logic [RGB_W-1:0] r_rgb_d;
  logic [HCNT_W-1:0] r_hhi, r_hlo;
  logic [VCNT_W-1:0] r_vhi, r_vlo;
  logic             r_hseen, r_vseen, r_hpol, r_vpol;
  logic             r_hs_out, r_vs_out;
  logic [RGB_W-1:0] r_rgb_out;
  logic             w_hrise, w_vrise, w_hpol_nxt, w_vpol_nxt, w_hact, w_vact;

  assign w_hrise = r_hs_d & ~r_hs_dd;
  assign w_vrise = r_vs_d & ~r_vs_dd;

  // Stage 1 capture plus previous-value copies for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_d    <= 1'b0;
      r_vs_d    <= 1'b0;
      r_hs_dd   <= 1'b0;
      r_vs_dd   <= 1'b0;
      r_rgb_d   <= '0;
      r_stg_vld <= 1'b0;
    end else begin
      r_hs_d    <= hs_in;
      r_vs_d    <= vs_in;
      r_hs_dd   <= r_hs_d;
      r_vs_dd   <= r_vs_d;
      r_rgb_d   <= {r_in, g_in, b_in};
      r_stg_vld <= 1'b1;
    end
  end

  // Polarity decision; the first period after reset is partial and only arms the seen flag
  always_comb begin
    w_hpol_nxt = r_hpol;
    w_vpol_nxt = r_vpol;
    if (w_hrise && r_hseen) begin
      if (r_hhi < r_hlo)      w_hpol_nxt = 1'b1;
      else if (r_hhi > r_hlo) w_hpol_nxt = 1'b0;
    end
    if (w_vrise && r_vseen) begin
      if (r_vhi < r_vlo)      w_vpol_nxt = 1'b1;
      else if (r_vhi > r_vlo) w_vpol_nxt = 1'b0;
    end
  end

  assign w_hact = w_hpol_nxt ? r_hs_d : ~r_hs_d;
  assign w_vact = w_vpol_nxt ? r_vs_d : ~r_vs_d;

  // Saturating high/low time counters; horizontal per cycle, vertical per line
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hhi   <= '0;
      r_hlo   <= '0;
      r_vhi   <= '0;
      r_vlo   <= '0;
      r_hseen <= 1'b0;
      r_vseen <= 1'b0;
      r_hpol  <= 1'b0;
      r_vpol  <= 1'b0;
    end else begin
      r_hpol <= w_hpol_nxt;
      r_vpol <= w_vpol_nxt;
      if (w_hrise) begin
        r_hhi   <= '0;
        r_hlo   <= '0;
        r_hseen <= 1'b1;
      end else if (r_hs_d) begin
        if (r_hhi != HMAX) r_hhi <= r_hhi + HCNT_W'(1);
      end else begin
        if (r_hlo != HMAX) r_hlo <= r_hlo + HCNT_W'(1);
      end
      // A coincident line edge still counts into the freshly cleared frame
      if (w_vrise) begin
        r_vhi   <= (w_hrise && r_vs_d) ? VCNT_W'(1) : '0;
        r_vlo   <= '0;
        r_vseen <= 1'b1;
      end else if (w_hrise) begin
        if (r_vs_d) begin
          if (r_vhi != VMAX) r_vhi <= r_vhi + VCNT_W'(1);
        end else begin
          if (r_vlo != VMAX) r_vlo <= r_vlo + VCNT_W'(1);
        end
      end
    end
  end

  // Stage 2 outputs, held at reset values until stage 1 holds real data
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_out  <= 1'b1;
      r_vs_out  <= 1'b1;
      r_rgb_out <= '0;
    end else if (r_stg_vld) begin
      r_hs_out  <= ~w_hact;
      r_vs_out  <= ~w_vact;
      r_rgb_out <= (w_hact | w_vact) ? '0 : r_rgb_d;
    end
  end

`ifdef CSYNC_EN
  logic r_csync;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)       r_csync <= 1'b1;
    else if (r_stg_vld) r_csync <= ~(w_hact ^ w_vact);
  end
  assign csync_out = r_csync;
`else
  assign csync_out = 1'b1;
`endif

  assign hs_out = r_hs_out;
  assign vs_out = r_vs_out;
  assign {r_out, g_out, b_out} = r_rgb_out;
  assign hpol = r_hpol;
  assign vpol = r_vpol;
endmodule

// File: tb/tb_video_sync_norm.sv
// Randomised bench for video_sync_norm against a period-based behavioural model.
module tb_video_sync_norm;
  localparam int HMAXV = 4095;
  localparam int VMAXV = 1023;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       hs_in = 1'b0, vs_in = 1'b0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_out, vs_out, csync_out, hpol, vpol;
  logic [5:0] r_out, g_out, b_out;

  int n_chk = 0;
  int n_err = 0;

  video_sync_norm #(.HCNT_W(12), .VCNT_W(10)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .csync_out(csync_out), .hpol(hpol), .vpol(vpol)
  );

  always #5 clk_sys = ~clk_sys;

  // Model: last two sampled inputs, unbounded period lengths, learned polarity
  bit        m_h1, m_h2, m_v1, m_v2, m_started;
  bit [17:0] m_rgb1;
  int        m_hhi, m_hlo, m_vhi, m_vlo;
  bit        m_hseen, m_vseen, m_hpol, m_vpol;
  bit        e_hs, e_vs, e_cs;
  bit [17:0] e_rgb;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_v1 = 0; m_v2 = 0; m_started = 0; m_rgb1 = '0;
    m_hhi = 0; m_hlo = 0; m_vhi = 0; m_vlo = 0;
    m_hseen = 0; m_vseen = 0; m_hpol = 0; m_vpol = 0;
    e_hs = 1; e_vs = 1; e_cs = 1; e_rgb = '0;
  endtask

  task automatic model_step();
    bit hr, vr, hact, vact;
    hr = m_h1 && !m_h2;
    vr = m_v1 && !m_v2;
    if (hr) begin
      if (m_hseen) begin
        if (sat(m_hhi, HMAXV) < sat(m_hlo, HMAXV)) m_hpol = 1;
        else if (sat(m_hhi, HMAXV) > sat(m_hlo, HMAXV)) m_hpol = 0;
      end
      m_hseen = 1; m_hhi = 0; m_hlo = 0;
    end else if (m_h1) m_hhi++;
    else m_hlo++;
    if (vr) begin
      if (m_vseen) begin
        if (sat(m_vhi, VMAXV) < sat(m_vlo, VMAXV)) m_vpol = 1;
        else if (sat(m_vhi, VMAXV) > sat(m_vlo, VMAXV)) m_vpol = 0;
      end
      m_vseen = 1;
      m_vhi = (hr && m_v1) ? 1 : 0;
      m_vlo = 0;
    end else if (hr) begin
      if (m_v1) m_vhi++;
      else m_vlo++;
    end
    if (m_started) begin
      hact = m_hpol ? m_h1 : !m_h1;
      vact = m_vpol ? m_v1 : !m_v1;
      e_hs = !hact;
      e_vs = !vact;
      e_rgb = (hact || vact) ? 18'd0 : m_rgb1;
`ifdef CSYNC_EN
      e_cs = !(hact ^ vact);
`else
      e_cs = 1;
`endif
    end
    m_started = 1;
    m_h2 = m_h1; m_h1 = hs_in;
    m_v2 = m_v1; m_v1 = vs_in;
    m_rgb1 = {r_in, g_in, b_in};
  endtask

  task automatic compare_all();
    chk("hs_out", hs_out, e_hs);
    chk("vs_out", vs_out, e_vs);
    chk("csync_out", csync_out, e_cs);
    chk("rgb_out", {r_out, g_out, b_out}, e_rgb);
    chk("hpol", hpol, m_hpol);
    chk("vpol", vpol, m_vpol);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (reset_n) model_step();
    #1;
    compare_all();
  endtask

  task automatic rand_inputs();
    hs_in = 1'($urandom); vs_in = 1'($urandom);
    r_in = 6'($urandom); g_in = 6'($urandom); b_in = 6'($urandom);
  endtask

  task automatic check_reset_literals(input string tag);
    chk({tag, "_hs"}, hs_out, 1);
    chk({tag, "_vs"}, vs_out, 1);
    chk({tag, "_cs"}, csync_out, 1);
    chk({tag, "_rgb"}, {r_out, g_out, b_out}, 0);
    chk({tag, "_hpol"}, hpol, 0);
    chk({tag, "_vpol"}, vpol, 0);
  endtask

  // Asserts reset away from the clock edge, holds it, releases and checks the output hold
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_literals("rst_async");
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      tick();
      check_reset_literals("rst_hold");
    end
    reset_n = 1'b1;
    rand_inputs();
    tick();
    chk("post_rst_hs_hold", hs_out, 1);
    chk("post_rst_rgb_hold", {r_out, g_out, b_out}, 0);
  endtask

  task automatic gen_frames(input int ncyc, input int hper, input int hpw, input bit hhigh,
                            input int vlines, input int vpw, input bit vhigh, input bit fixed_rgb);
    for (int i = 0; i < ncyc; i++) begin
      int x, line;
      x = i % hper;
      line = (i / hper) % vlines;
      hs_in = (x < hpw) ? hhigh : !hhigh;
      vs_in = (line < vpw) ? vhigh : !vhigh;
      if (fixed_rgb) begin
        r_in = 6'h2A; g_in = 6'h2A; b_in = 6'h2A;
      end else begin
        r_in = 6'($urandom); g_in = 6'($urandom); b_in = 6'($urandom);
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b1;
    model_reset();
    #2;
    do_reset(4);

    // Active-low hsync, long single frame so vsync stays inactive-high
    gen_frames(3 * 2048, 2048, 240, 1'b0, 1000, 0, 1'b0, 1'b1);
    chk("hpol_active_low", hpol, 0);

    // Active-high hsync
    gen_frames(3 * 2048 + 16, 2048, 240, 1'b1, 1000, 0, 1'b0, 1'b1);
    chk("hpol_active_high", hpol, 1);

    // Active-high vsync, 3 of 20 lines, edges coincide with hsync edges
    gen_frames(3 * 20 * 64 + 8, 64, 8, 1'b1, 20, 3, 1'b1, 1'b0);
    chk("vpol_active_high", vpol, 1);

    // Stuck-high hsync, then resume
    hs_in = 1'b1; vs_in = 1'b0;
    for (int i = 0; i < 5000; i++) tick();
    chk("hpol_stuck", hpol, 1);
    gen_frames(4 * 64, 64, 8, 1'b1, 1000, 0, 1'b0, 1'b0);
    chk("hpol_resumed", hpol, 1);

    // Active-low hsync and vsync for composite sync
    gen_frames(3 * 12 * 48 + 5, 48, 6, 1'b0, 12, 2, 1'b0, 1'b0);

    // Mid-line reset, then randomised sync shapes
    repeat (37) tick();
    do_reset(3);
    for (int k = 0; k < 6; k++) begin
      int hper, hpw, vl, vpw;
      hper = 16 + int'($urandom_range(0, 80));
      hpw  = 1 + int'($urandom_range(0, hper - 2));
      vl   = 4 + int'($urandom_range(0, 8));
      vpw  = 1 + int'($urandom_range(0, vl - 2));
      gen_frames(hper * vl * 3 + int'($urandom_range(0, 30)), hper, hpw, 1'($urandom),
                 vl, vpw, 1'($urandom), 1'b0);
      if (k == 2) do_reset(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
